// File: rtl/dmem_arb_pkg.sv
// Shared constants and owner-state encoding for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 4;

    typedef logic [1:0] own_state_t;

    localparam own_state_t IDLE = 2'd0;
    localparam own_state_t OWN0 = 2'd1;
    localparam own_state_t OWN1 = 2'd2;

endpackage

// File: rtl/arb_pick2.sv
// Combinational port selection: bounded-burst ownership with alternating tie-break.
module arb_pick2
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  own_state_t       state,
    input  logic [CNT_W-1:0] cnt,
    input  logic             last,
    input  logic             req0,
    input  logic             req1,
    output logic             sel,
    output logic             sel_valid
);

    localparam logic [CNT_W-1:0] BURST = MAX_BURST[CNT_W-1:0];

    always_comb begin
        sel       = 1'b0;
        sel_valid = req0 | req1;
        case (state)
            OWN0: begin
                // Owner keeps the port until its burst is spent while the other waits.
                if (req0 && ((cnt < BURST) || !req1)) begin
                    sel = 1'b0;
                end else begin
                    sel = req1;
                end
            end
            OWN1: begin
                if (req1 && ((cnt < BURST) || !req0)) begin
                    sel = 1'b1;
                end else begin
                    sel = !req0 && req1;
                end
            end
            default: begin
                if (req0 && req1) begin
                    sel = ~last;
                end else begin
                    sel = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing a single-port synchronous-read data memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wren0,
    input  logic              wren1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    own_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             rvalid0_q, rvalid1_q;
    logic             sel, sel_valid;

    arb_pick2 #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .state     (state_q),
        .cnt       (cnt_q),
        .last      (last_q),
        .req0      (req0),
        .req1      (req1),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    // Gating with reset keeps grants low while reset is held, even if requests are up.
    assign gnt0 = reset & sel_valid & ~sel & req0;
    assign gnt1 = reset & sel_valid & sel & req1;

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        if (sel_valid) begin
            state_d = sel ? OWN1 : OWN0;
            if (state_q == state_d) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d  = 4'd1;
                last_d = sel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rvalid0_q <= gnt0 & ~wren0;
            rvalid1_q <= gnt1 & ~wren1;
        end
    end

    assign mem_address = (sel_valid && sel) ? addr1 : addr0;
    assign mem_data    = (sel_valid && sel) ? wdata1 : wdata0;
    assign mem_wren    = (gnt0 & wren0) | (gnt1 & wren1);

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? mem_q : '0;
    assign rdata1  = rvalid1_q ? mem_q : '0;

endmodule
